jtframe_dwnld_pack: RTL

Byte-to-word write packer between the ROM download stage and the SDRAM programming port. Accepts single-byte-lane writes (address, 16-bit replicated data, active-low lane mask) and merges the even/odd byte pairs of one word into a single 16-bit write. Buffers the packed writes in a small FIFO and issues them to the SDRAM controller with a req/ack handshake. This halves SDRAM programming traffic and absorbs controller latency during download.

---
 rtl/jtframe_dwnld_pack.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/jtframe_dwnld_pack.sv
// Byte-to-word write packer for ROM download: merges even/odd byte writes to one
// word, queues packed words in a small FIFO and hands them to SDRAM via req/ack.
module jtframe_dwnld_pack #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  output logic        prog_ack,
  output logic [21:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_mask,
  output logic [1:0]  wr_ba,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic        overrun,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FLUSH_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [1:0]  ba;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{addr: '0, data: '0, mask: 2'b11, ba: '0};

  entry_t          mem [DEPTH];
  entry_t          pend_reg, pend_next, push_entry, in_entry;
  logic            pend_valid_reg, pend_valid_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [TW-1:0]   tmo_reg;
  logic            prog_ack_reg, wr_req_reg, overrun_reg, idle_reg;
  logic            waiting_prev_reg;
  logic [21:0]     prev_addr_reg;
  logic [15:0]     prev_data_reg;
  logic [1:0]      prev_mask_reg;

  logic            full, empty, accept, same_word, flush, push, pop, waiting, changed;
  logic [1:0]      merged_mask;
  logic [15:0]     merged_data;

  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  // The !prog_ack term keeps the byte held during its ack cycle from being taken twice
  assign accept = prog_we && !prog_ack_reg && (!pend_valid_reg || !full);
  assign pop    = wr_ack && wr_req_reg && !empty;

  assign same_word   = pend_valid_reg && (prog_addr == pend_reg.addr) && (prog_ba == pend_reg.ba)
                       && ((~pend_reg.mask & ~prog_mask) == 2'b00);
  assign merged_mask = pend_reg.mask & prog_mask;
  assign merged_data = {prog_mask[1] ? pend_reg.data[15:8] : prog_data[15:8],
                        prog_mask[0] ? pend_reg.data[7:0]  : prog_data[7:0]};
  assign flush       = pend_valid_reg && !accept && !full && (!downloading || tmo_reg == TMO_MAX);
  assign in_entry    = '{addr: prog_addr, data: prog_data, mask: prog_mask, ba: prog_ba};

  always_comb begin
    push            = 1'b0;
    push_entry      = pend_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    if (accept) begin
      if (!pend_valid_reg) begin
        pend_next       = in_entry;
        pend_valid_next = 1'b1;
      end else if (same_word) begin
        pend_next.mask = merged_mask;
        pend_next.data = merged_data;
        if (merged_mask == 2'b00) begin
          push            = 1'b1;
          push_entry      = pend_next;
          pend_valid_next = 1'b0;
        end
      end else begin
        push            = 1'b1;
        pend_next       = in_entry;
        pend_valid_next = 1'b1;
      end
    end else if (flush) begin
      push            = 1'b1;
      pend_valid_next = 1'b0;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  assign waiting = prog_we && !accept && !prog_ack_reg;
  assign changed = (prog_addr != prev_addr_reg) || (prog_data != prev_data_reg)
                   || (prog_mask != prev_mask_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= EMPTY_ENTRY;
      pend_reg         <= EMPTY_ENTRY;
      pend_valid_reg   <= 1'b0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      tmo_reg          <= '0;
      prog_ack_reg     <= 1'b0;
      wr_req_reg       <= 1'b0;
      overrun_reg      <= 1'b0;
      idle_reg         <= 1'b1;
      waiting_prev_reg <= 1'b0;
      prev_addr_reg    <= '0;
      prev_data_reg    <= '0;
      prev_mask_reg    <= 2'b11;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= push_entry;
        wr_ptr_reg      <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      prog_ack_reg   <= accept;
      // Rises a cycle after the first push, but falls together with the last pop
      wr_req_reg     <= (count_reg != '0) && (count_next != '0);
      idle_reg       <= !downloading && !pend_valid_reg && empty;

      if (accept || flush)
        tmo_reg <= '0;
      else if (pend_valid_reg && tmo_reg != TMO_MAX)
        tmo_reg <= tmo_reg + 1'b1;

      // A held byte must stay stable until accepted; any change means it was lost
      if (waiting && waiting_prev_reg && changed) overrun_reg <= 1'b1;
      waiting_prev_reg <= waiting;
      prev_addr_reg    <= prog_addr;
      prev_data_reg    <= prog_data;
      prev_mask_reg    <= prog_mask;
    end
  end

  assign prog_ack = prog_ack_reg;
  assign wr_addr  = mem[rd_ptr_reg].addr;
  assign wr_data  = mem[rd_ptr_reg].data;
  assign wr_mask  = mem[rd_ptr_reg].mask;
  assign wr_ba    = mem[rd_ptr_reg].ba;
  assign wr_req   = wr_req_reg;
  assign overrun  = overrun_reg;
  assign idle     = idle_reg;

endmodule
